// File: rtl/memory_stage_access_unit_pkg.sv
// Opcodes, FSM state type and store-lane helpers shared by the memory-stage access unit.
package mips_mem_pkg;

    localparam logic [5:0] LB  = 6'h20;
    localparam logic [5:0] LH  = 6'h21;
    localparam logic [5:0] LWL = 6'h22;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] LBU = 6'h24;
    localparam logic [5:0] LHU = 6'h25;
    localparam logic [5:0] LWR = 6'h26;
    localparam logic [5:0] SB  = 6'h28;
    localparam logic [5:0] SH  = 6'h29;
    localparam logic [5:0] SW  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    // Byte loads/stores and LWL/LWR can never be misaligned; anything unrecognised is word width.
    function automatic logic is_misaligned(input logic is_load, input logic [5:0] op,
                                           input logic [1:0] b);
        logic narrow;
        logic half;
        logic result;
        if (is_load) begin
            narrow = (op == LB) || (op == LBU) || (op == LWL) || (op == LWR);
            half   = (op == LH) || (op == LHU);
        end else begin
            narrow = (op == SB);
            half   = (op == SH);
        end
        if (narrow) begin
            result = 1'b0;
        end else if (half) begin
            result = b[0];
        end else begin
            result = (b != 2'b00);
        end
        return result;
    endfunction

    function automatic logic [3:0] store_byteenable(input logic [5:0] op, input logic [1:0] b);
        logic [3:0] be;
        case (op)
            SB:      be = 4'b0001 << b;
            SH:      be = b[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicating the datum onto every lane lets the byteenable alone select the target bytes.
    function automatic logic [31:0] store_writedata(input logic [5:0] op, input logic [31:0] rt);
        logic [31:0] wd;
        case (op)
            SB:      wd = {4{rt[7:0]}};
            SH:      wd = {2{rt[15:0]}};
            default: wd = rt;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/memory_stage_access_unit_extractor.sv
// Combinational load alignment: picks the addressed byte/half, extends it, or merges LWL/LWR with rt.
module load_data_extractor
    import mips_mem_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  b,
    input  logic [31:0] readdata,
    input  logic [31:0] rt,
    output logic [31:0] result
);

    logic [7:0]  lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] lwl_keep;
    logic [31:0] lwr_keep;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = readdata[8*gi +: 8];
    end

    always_comb begin
        sel_byte = lane[b];
        sel_half = b[1] ? readdata[31:16] : readdata[15:0];

        // rt bytes that survive the unaligned merge
        case (b)
            2'd0:    begin lwl_keep = 32'h00FF_FFFF; lwr_keep = 32'h0000_0000; end
            2'd1:    begin lwl_keep = 32'h0000_FFFF; lwr_keep = 32'hFF00_0000; end
            2'd2:    begin lwl_keep = 32'h0000_00FF; lwr_keep = 32'hFFFF_0000; end
            default: begin lwl_keep = 32'h0000_0000; lwr_keep = 32'hFFFF_FF00; end
        endcase

        case (op)
            LB:      result = {{24{sel_byte[7]}}, sel_byte};
            LBU:     result = {24'h00_0000, sel_byte};
            LH:      result = {{16{sel_half[15]}}, sel_half};
            LHU:     result = {16'h0000, sel_half};
            LWL:     result = (readdata << {~b, 3'b000}) | (rt & lwl_keep);
            LWR:     result = (readdata >> {b, 3'b000}) | (rt & lwr_keep);
            default: result = readdata;
        endcase
    end

endmodule

// File: rtl/memory_stage_access_unit.sv
// Memory-stage bus master: one Avalon-style transaction per load/store, stalling the pipe until done.
module memory_stage_access_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memory_to_register_memory,
    input  logic        memory_write_memory,
    input  logic        HALT_memory,
    input  logic [5:0]  op_memory,
    input  logic [31:0] ALU_output_memory,
    input  logic [31:0] write_data_memory,
    output logic [31:0] data_address,
    output logic        data_read,
    output logic        data_write,
    output logic [3:0]  data_byteenable,
    output logic [31:0] data_writedata,
    input  logic        data_waitrequest,
    input  logic [31:0] data_readdata,
    output logic        stall_memory,
    output logic [31:0] load_data_memory,
    output logic        address_error,
    output logic        bus_timeout
);

    localparam int unsigned CNT_W = $clog2(WAIT_TIMEOUT + 2);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST =
        CNT_W'((WAIT_TIMEOUT == 0) ? 0 : WAIT_TIMEOUT - 1);

    mem_state_t state_q, state_d;
    logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;
    logic        data_read_q, data_read_d;
    logic        data_write_q, data_write_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic [31:0] address_q, address_d;
    logic [31:0] writedata_q, writedata_d;
    logic [5:0]  op_q, op_d;
    logic [1:0]  b_q, b_d;
    logic [31:0] rt_q, rt_d;
    logic        is_load_q, is_load_d;
    logic [31:0] load_data_q, load_data_d;
    logic        address_error_q, address_error_d;
    logic        bus_timeout_q, bus_timeout_d;

    logic        access;
    logic        req_is_load;
    logic [1:0]  req_b;
    logic [31:0] extracted;

    assign access      = (memory_to_register_memory | memory_write_memory) & ~HALT_memory;
    assign req_is_load = memory_to_register_memory;
    assign req_b       = ALU_output_memory[1:0];

    load_data_extractor u_extractor (
        .op       (op_q),
        .b        (b_q),
        .readdata (data_readdata),
        .rt       (rt_q),
        .result   (extracted)
    );

    always_comb begin
        state_d         = state_q;
        timeout_cnt_d   = timeout_cnt_q;
        data_read_d     = data_read_q;
        data_write_d    = data_write_q;
        byteenable_d    = byteenable_q;
        address_d       = address_q;
        writedata_d     = writedata_q;
        op_d            = op_q;
        b_d             = b_q;
        rt_d            = rt_q;
        is_load_d       = is_load_q;
        load_data_d     = load_data_q;
        address_error_d = 1'b0;
        bus_timeout_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (access) begin
                    if (is_misaligned(req_is_load, op_memory, req_b)) begin
                        state_d         = DONE;
                        address_error_d = 1'b1;
                        if (req_is_load) begin
                            load_data_d = 32'h0000_0000;
                        end
                    end else begin
                        state_d       = REQ;
                        timeout_cnt_d = '0;
                        address_d     = {ALU_output_memory[31:2], 2'b00};
                        op_d          = op_memory;
                        b_d           = req_b;
                        rt_d          = write_data_memory;
                        is_load_d     = req_is_load;
                        data_read_d   = req_is_load;
                        data_write_d  = ~req_is_load;
                        byteenable_d  = req_is_load ? 4'b1111
                                                    : store_byteenable(op_memory, req_b);
                        writedata_d   = req_is_load ? 32'h0000_0000
                                                    : store_writedata(op_memory, write_data_memory);
                    end
                end
            end
            REQ: begin
                if (!data_waitrequest) begin
                    data_read_d  = 1'b0;
                    data_write_d = 1'b0;
                    state_d      = is_load_q ? RESP : DONE;
                end else if ((WAIT_TIMEOUT != 0) && (timeout_cnt_q == TIMEOUT_LAST)) begin
                    data_read_d   = 1'b0;
                    data_write_d  = 1'b0;
                    state_d       = DONE;
                    bus_timeout_d = 1'b1;
                    if (is_load_q) begin
                        load_data_d = 32'h0000_0000;
                    end
                end else begin
                    timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                load_data_d = extracted;
                state_d     = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            timeout_cnt_q   <= '0;
            data_read_q     <= 1'b0;
            data_write_q    <= 1'b0;
            byteenable_q    <= 4'b0000;
            address_q       <= 32'h0000_0000;
            writedata_q     <= 32'h0000_0000;
            op_q            <= 6'h00;
            b_q             <= 2'b00;
            rt_q            <= 32'h0000_0000;
            is_load_q       <= 1'b0;
            load_data_q     <= 32'h0000_0000;
            address_error_q <= 1'b0;
            bus_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            timeout_cnt_q   <= timeout_cnt_d;
            data_read_q     <= data_read_d;
            data_write_q    <= data_write_d;
            byteenable_q    <= byteenable_d;
            address_q       <= address_d;
            writedata_q     <= writedata_d;
            op_q            <= op_d;
            b_q             <= b_d;
            rt_q            <= rt_d;
            is_load_q       <= is_load_d;
            load_data_q     <= load_data_d;
            address_error_q <= address_error_d;
            bus_timeout_q   <= bus_timeout_d;
        end
    end

    // Stall drops only in DONE so the pipeline advances exactly once per access.
    assign stall_memory     = access & (state_q != DONE);
    assign data_address     = address_q;
    assign data_read        = data_read_q;
    assign data_write       = data_write_q;
    assign data_byteenable  = byteenable_q;
    assign data_writedata   = writedata_q;
    assign load_data_memory = load_data_q;
    assign address_error    = address_error_q;
    assign bus_timeout      = bus_timeout_q;

endmodule

// File: tb/tb_memory_stage_access_unit.sv
// Scoreboard bench: stimulus pushes expected bus/result records, a negedge monitor pops and compares.
module tb_memory_stage_access_unit;
    import mips_mem_pkg::*;

    localparam int WT = 4;

    logic        clk;
    logic        reset;
    logic        memory_to_register_memory;
    logic        memory_write_memory;
    logic        HALT_memory;
    logic [5:0]  op_memory;
    logic [31:0] ALU_output_memory;
    logic [31:0] write_data_memory;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [3:0]  data_byteenable;
    logic [31:0] data_writedata;
    logic        data_waitrequest;
    logic [31:0] data_readdata;
    logic        stall_memory;
    logic [31:0] load_data_memory;
    logic        address_error;
    logic        bus_timeout;

    memory_stage_access_unit #(.WAIT_TIMEOUT(WT)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .memory_to_register_memory (memory_to_register_memory),
        .memory_write_memory       (memory_write_memory),
        .HALT_memory               (HALT_memory),
        .op_memory                 (op_memory),
        .ALU_output_memory         (ALU_output_memory),
        .write_data_memory         (write_data_memory),
        .data_address              (data_address),
        .data_read                 (data_read),
        .data_write                (data_write),
        .data_byteenable           (data_byteenable),
        .data_writedata            (data_writedata),
        .data_waitrequest          (data_waitrequest),
        .data_readdata             (data_readdata),
        .stall_memory              (stall_memory),
        .load_data_memory          (load_data_memory),
        .address_error             (address_error),
        .bus_timeout               (bus_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic        chk_load;
        logic [31:0] load_data;
        logic        aerr;
        logic        tout;
        int          stall_cyc;
        int          req_cyc;
    } res_exp_t;

    bus_exp_t bus_q[$];
    res_exp_t res_q[$];

    int checks;
    int failures;
    int slave_waits;
    logic [31:0] slave_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic exp_bus(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata);
        bus_exp_t e;
        e.wr = wr; e.addr = addr; e.be = be; e.wdata = wdata;
        bus_q.push_back(e);
    endtask

    task automatic exp_res(input logic chk_load, input logic [31:0] load_data, input logic aerr,
                           input logic tout, input int stall_cyc, input int req_cyc);
        res_exp_t r;
        r.chk_load = chk_load; r.load_data = load_data; r.aerr = aerr; r.tout = tout;
        r.stall_cyc = stall_cyc; r.req_cyc = req_cyc;
        res_q.push_back(r);
    endtask

    // Drive one access and hold it until the DUT releases the stall.
    task automatic run_txn(input logic ld, input logic st, input logic [5:0] op,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int waits, input logic [31:0] rdata);
        int n;
        @(posedge clk); #2;
        memory_to_register_memory = ld;
        memory_write_memory       = st;
        HALT_memory               = 1'b0;
        op_memory                 = op;
        ALU_output_memory         = addr;
        write_data_memory         = wd;
        slave_waits               = waits;
        slave_rdata               = rdata;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (!stall_memory) break;
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL txn_complete: stall still high after %0d cycles, required release", n);
        end
        @(posedge clk); #2;
        memory_to_register_memory = 1'b0;
        memory_write_memory       = 1'b0;
    endtask

    // Bus slave: waitrequest for the configured cycles, readdata only in the cycle after acceptance.
    initial begin
        logic acc_prev;
        logic started;
        int   wait_cnt;
        data_waitrequest = 1'b0;
        data_readdata    = 32'h5A5A_5A5A;
        started  = 1'b0;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            acc_prev = data_read & ~data_waitrequest & ~reset;
            @(posedge clk); #1;
            data_readdata = acc_prev ? slave_rdata : 32'h5A5A_5A5A;
            if (!(data_read | data_write)) begin
                started          = 1'b0;
                data_waitrequest = 1'b0;
            end else begin
                if (!started) begin
                    started  = 1'b1;
                    wait_cnt = slave_waits;
                end
                data_waitrequest = (wait_cnt != 0);
                if (wait_cnt != 0) wait_cnt--;
            end
        end
    end

    // Monitor: compares accepted bus requests and completed accesses against the queues.
    initial begin
        int       stall_cnt;
        int       req_cnt;
        int       txn;
        logic     acc;
        bus_exp_t e;
        res_exp_t r;
        stall_cnt = 0;
        req_cnt   = 0;
        txn       = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_cnt = 0;
                req_cnt   = 0;
                continue;
            end
            acc = (memory_to_register_memory | memory_write_memory) & ~HALT_memory;
            if (stall_memory) stall_cnt++;
            if (data_read | data_write) begin
                req_cnt++;
                if (!data_waitrequest) begin
                    if (bus_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL bus_unexpected: got request addr 0x%08h, required none",
                                 data_address);
                    end else begin
                        e = bus_q.pop_front();
                        check("bus_write", 32'(data_write), 32'(e.wr));
                        check("bus_read", 32'(data_read), 32'(!e.wr));
                        check("bus_addr", data_address, e.addr);
                        check("bus_be", 32'(data_byteenable), 32'(e.be));
                        if (e.wr) check("bus_wdata", data_writedata, e.wdata);
                    end
                end
            end
            if (acc && !stall_memory) begin
                txn++;
                if (res_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL res_unexpected: got completion, required none");
                end else begin
                    r = res_q.pop_front();
                    check("address_error", 32'(address_error), 32'(r.aerr));
                    check("bus_timeout", 32'(bus_timeout), 32'(r.tout));
                    check("stall_cycles", 32'(stall_cnt), 32'(r.stall_cyc));
                    check("req_cycles", 32'(req_cnt), 32'(r.req_cyc));
                    if (r.chk_load) check("load_data", load_data_memory, r.load_data);
                end
                $display("txn %0d: op=0x%02h addr=0x%08h load_data=0x%08h aerr=%0b tout=%0b stall=%0d req=%0d",
                         txn, op_memory, ALU_output_memory, load_data_memory,
                         address_error, bus_timeout, stall_cnt, req_cnt);
                stall_cnt = 0;
                req_cnt   = 0;
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset                     = 1'b1;
        memory_to_register_memory = 1'b0;
        memory_write_memory       = 1'b0;
        HALT_memory               = 1'b0;
        op_memory                 = 6'h00;
        ALU_output_memory         = 32'h0;
        write_data_memory         = 32'h0;
        slave_waits               = 0;
        slave_rdata               = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_read", 32'(data_read), 32'd0);
        check("rst_write", 32'(data_write), 32'd0);
        check("rst_be", 32'(data_byteenable), 32'd0);
        check("rst_addr", data_address, 32'd0);
        check("rst_wdata", data_writedata, 32'd0);
        check("rst_load", load_data_memory, 32'd0);
        check("rst_aerr", 32'(address_error), 32'd0);
        check("rst_tout", 32'(bus_timeout), 32'd0);
        check("rst_stall", 32'(stall_memory), 32'd0);
        reset = 1'b0;

        exp_bus(1'b1, 32'h100, 4'b1111, 32'hDEADBEEF);
        exp_res(1'b0, 32'h0, 1'b0, 1'b0, 2, 1);
        run_txn(1'b0, 1'b1, SW, 32'h100, 32'hDEADBEEF, 0, 32'h0);

        exp_bus(1'b0, 32'h200, 4'b1111, 32'h0);
        exp_res(1'b1, 32'hFFFFFF80, 1'b0, 1'b0, 3, 1);
        run_txn(1'b1, 1'b0, LB, 32'h203, 32'h0, 0, 32'h80123456);

        exp_bus(1'b0, 32'h200, 4'b1111, 32'h0);
        exp_res(1'b1, 32'h00000080, 1'b0, 1'b0, 3, 1);
        run_txn(1'b1, 1'b0, LBU, 32'h203, 32'h0, 0, 32'h80123456);

        exp_bus(1'b1, 32'h300, 4'b1100, 32'hABCDABCD);
        exp_res(1'b0, 32'h0, 1'b0, 1'b0, 5, 4);
        run_txn(1'b0, 1'b1, SH, 32'h302, 32'h0000ABCD, 3, 32'h0);

        exp_bus(1'b0, 32'h400, 4'b1111, 32'h0);
        exp_res(1'b1, 32'hCCDD3344, 1'b0, 1'b0, 3, 1);
        run_txn(1'b1, 1'b0, LWL, 32'h401, 32'h11223344, 0, 32'hAABBCCDD);

        exp_bus(1'b0, 32'h400, 4'b1111, 32'h0);
        exp_res(1'b1, 32'h11AABBCC, 1'b0, 1'b0, 3, 1);
        run_txn(1'b1, 1'b0, LWR, 32'h401, 32'h11223344, 0, 32'hAABBCCDD);

        exp_res(1'b1, 32'h00000000, 1'b1, 1'b0, 1, 0);
        run_txn(1'b1, 1'b0, LW, 32'h502, 32'h0, 0, 32'h0);

        exp_bus(1'b0, 32'h600, 4'b1111, 32'h0);
        exp_res(1'b1, 32'hFFFF8001, 1'b0, 1'b0, 3, 1);
        run_txn(1'b1, 1'b0, LH, 32'h602, 32'h0, 0, 32'h80017FFF);

        exp_bus(1'b0, 32'h600, 4'b1111, 32'h0);
        exp_res(1'b1, 32'h00007FFF, 1'b0, 1'b0, 3, 1);
        run_txn(1'b1, 1'b0, LHU, 32'h600, 32'h0, 0, 32'h80017FFF);

        exp_bus(1'b1, 32'h700, 4'b0010, 32'hA5A5A5A5);
        exp_res(1'b0, 32'h0, 1'b0, 1'b0, 2, 1);
        run_txn(1'b0, 1'b1, SB, 32'h701, 32'h000000A5, 0, 32'h0);

        exp_bus(1'b0, 32'h800, 4'b1111, 32'h0);
        exp_res(1'b1, 32'h12345678, 1'b0, 1'b0, 5, 3);
        run_txn(1'b1, 1'b0, LW, 32'h800, 32'h0, 2, 32'h12345678);

        exp_bus(1'b0, 32'h400, 4'b1111, 32'h0);
        exp_res(1'b1, 32'hAABBCCDD, 1'b0, 1'b0, 3, 1);
        run_txn(1'b1, 1'b0, LWL, 32'h403, 32'h11223344, 0, 32'hAABBCCDD);

        exp_bus(1'b0, 32'h400, 4'b1111, 32'h0);
        exp_res(1'b1, 32'h01020304, 1'b0, 1'b0, 3, 1);
        run_txn(1'b1, 1'b0, LWR, 32'h400, 32'h11223344, 0, 32'h01020304);

        // misaligned store: error pulse, load result untouched
        exp_res(1'b1, 32'h01020304, 1'b1, 1'b0, 1, 0);
        run_txn(1'b0, 1'b1, SH, 32'h901, 32'h00001234, 0, 32'h0);

        exp_bus(1'b0, 32'hC04, 4'b1111, 32'h0);
        exp_res(1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 3, 1);
        run_txn(1'b1, 1'b0, 6'h30, 32'hC04, 32'h0, 0, 32'hCAFEF00D);

        exp_res(1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 1, 0);
        run_txn(1'b0, 1'b1, 6'h38, 32'hC06, 32'h0, 0, 32'h0);

        // HALT suppresses the access entirely
        @(posedge clk); #2;
        memory_to_register_memory = 1'b1;
        HALT_memory               = 1'b1;
        op_memory                 = LW;
        ALU_output_memory         = 32'hD00;
        slave_waits               = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("halt_stall", 32'(stall_memory), 32'd0);
            check("halt_read", 32'(data_read), 32'd0);
        end
        @(posedge clk); #2;
        memory_to_register_memory = 1'b0;
        HALT_memory               = 1'b0;

        exp_res(1'b1, 32'h00000000, 1'b0, 1'b1, 1 + WT, WT);
        run_txn(1'b1, 1'b0, LW, 32'hA00, 32'h0, 1000, 32'h0);

        exp_bus(1'b0, 32'hE00, 4'b1111, 32'h0);
        exp_res(1'b1, 32'h0F0F0F0F, 1'b0, 1'b0, 3, 1);
        run_txn(1'b1, 1'b0, LW, 32'hE00, 32'h0, 0, 32'h0F0F0F0F);

        // asynchronous reset while the read is being held off
        @(posedge clk); #2;
        memory_to_register_memory = 1'b1;
        op_memory                 = LW;
        ALU_output_memory         = 32'hB00;
        slave_waits               = 1000;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_pre_read", 32'(data_read), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_read", 32'(data_read), 32'd0);
        check("rst_mid_addr", data_address, 32'd0);
        check("rst_mid_be", 32'(data_byteenable), 32'd0);
        check("rst_mid_load", load_data_memory, 32'd0);
        check("rst_mid_stall", 32'(stall_memory), 32'd1);
        memory_to_register_memory = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        exp_bus(1'b1, 32'hF00, 4'b1111, 32'h12345678);
        exp_res(1'b0, 32'h0, 1'b0, 1'b0, 2, 1);
        run_txn(1'b0, 1'b1, SW, 32'hF00, 32'h12345678, 0, 32'h0);

        repeat (2) @(negedge clk);
        check("bus_q_empty", 32'(bus_q.size()), 32'd0);
        check("res_q_empty", 32'(res_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
